// File: rtl/idecode.sv
// bexkat1 decode stage: latches fetch IR/PC, splits fields, load-use/flush control.
// Optional illegal-type trap enabled by defining BEXKAT1_ILLEGAL_TRAP_EN.
module idecode #(
  parameter logic [63:0] NOP_IR = 64'h0,
  parameter int          RSEL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [63:0]       ir_i,
  input  logic [31:0]       pc_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              ex_valid_i,
  input  logic              ex_load_i,
  input  logic [RSEL_W-1:0] ex_rd_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [3:0]        type_o,
  output logic [3:0]        op_o,
  output logic [RSEL_W-1:0] ra_o,
  output logic [RSEL_W-1:0] rb_o,
  output logic [RSEL_W-1:0] rc_o,
  output logic [31:0]       imm_o,
  output logic              long_o,
  output logic              exc_o
);

  logic [63:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        full_q, full_d;
  logic        hazard;
  logic        src_hit;
  logic        load_en;
  logic        illegal;

  assign type_o = ir_q[31:28];
  assign op_o   = ir_q[27:24];
  assign ra_o   = ir_q[23:20];
  assign rb_o   = ir_q[19:16];
  assign rc_o   = ir_q[15:12];
  assign long_o = ir_q[0];
  assign imm_o  = long_o ? ir_q[63:32]
                         : {{17{ir_q[15]}}, ir_q[15:1]};
  assign pc_o   = pc_q;

`ifdef BEXKAT1_ILLEGAL_TRAP_EN
  logic exc_q, exc_d;

  assign illegal = full_q && (ir_q[31:28] >= 4'hA);
  assign exc_o   = exc_q;

  always_comb begin
    exc_d = 1'b0;
    if (!flush_i && load_en && (ir_i != NOP_IR)
        && (ir_i[31:28] >= 4'hA))
      exc_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) exc_q <= 1'b0;
    else       exc_q <= exc_d;
  end
`else
  assign illegal = 1'b0;
  assign exc_o   = 1'b0;
`endif

  // rc is only a source for ALU-reg encodings
  assign src_hit = (ex_rd_i == ra_o) || (ex_rd_i == rb_o)
                || ((type_o == 4'h1) && (ex_rd_i == rc_o));

  assign hazard  = full_q && !illegal && ex_valid_i
                && ex_load_i && src_hit;
  assign load_en = !stall_i && !hazard;

  assign stall_o = stall_i | hazard;
  assign valid_o = full_q & !hazard & !flush_i & !illegal;

  always_comb begin
    ir_d   = ir_q;
    pc_d   = pc_q;
    full_d = full_q;
    if (flush_i) begin
      ir_d   = NOP_IR;
      pc_d   = pc_i;
      full_d = 1'b0;
    end else if (load_en) begin
      ir_d   = ir_i;
      pc_d   = pc_i;
      full_d = (ir_i != NOP_IR);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_q   <= NOP_IR;
      pc_q   <= 32'h0;
      full_q <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      pc_q   <= pc_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_idecode.sv
// Directed-vector bench for idecode.
// Illegal-trap expectations follow BEXKAT1_ILLEGAL_TRAP_EN.
module tb_idecode;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] ir_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        stall_i;
  logic        ex_valid_i;
  logic        ex_load_i;
  logic [3:0]  ex_rd_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [3:0]  type_o;
  logic [3:0]  op_o;
  logic [3:0]  ra_o;
  logic [3:0]  rb_o;
  logic [3:0]  rc_o;
  logic [31:0] imm_o;
  logic        long_o;
  logic        exc_o;

  int n_checks = 0;
  int n_errors = 0;

  idecode dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ir_i       (ir_i),
    .pc_i       (pc_i),
    .flush_i    (flush_i),
    .stall_i    (stall_i),
    .ex_valid_i (ex_valid_i),
    .ex_load_i  (ex_load_i),
    .ex_rd_i    (ex_rd_i),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .pc_o       (pc_o),
    .type_o     (type_o),
    .op_o       (op_o),
    .ra_o       (ra_o),
    .rb_o       (rb_o),
    .rc_o       (rc_o),
    .imm_o      (imm_o),
    .long_o     (long_o),
    .exc_o      (exc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // inputs change 1ns after the edge, checks 1ns later
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i      = 1'b1;
    ir_i       = 64'h0;
    pc_i       = 32'h0;
    flush_i    = 1'b0;
    stall_i    = 1'b0;
    ex_valid_i = 1'b0;
    ex_load_i  = 1'b0;
    ex_rd_i    = 4'h0;
    #12;
    check("rst_valid", valid_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_exc",   exc_o,   0);
    check("rst_pc",    pc_o,    0);
    check("rst_type",  type_o,  0);
    check("rst_imm",   imm_o,   0);
    rst_i = 1'b0;

    // short decode
    tick();
    ir_i = 64'h0000_0000_1234_8002;
    pc_i = 32'h7000_0000;
    tick();
    ir_i = 64'hDEAD_BEEF_7012_0001;
    pc_i = 32'h7000_0004;
    #1;
    check("s_type",  type_o,  4'h1);
    check("s_op",    op_o,    4'h2);
    check("s_ra",    ra_o,    4'h3);
    check("s_rb",    rb_o,    4'h4);
    check("s_rc",    rc_o,    4'h8);
    check("s_imm",   imm_o,   32'hFFFF_C001);
    check("s_long",  long_o,  0);
    check("s_valid", valid_o, 1);
    check("s_pc",    pc_o,    32'h7000_0000);
    // rc is a source for ALU-reg: combinational hazard
    ex_valid_i = 1'b1;
    ex_load_i  = 1'b1;
    ex_rd_i    = 4'h8;
    #1;
    check("rc_haz_stall", stall_o, 1);
    check("rc_haz_valid", valid_o, 0);
    ex_load_i = 1'b0;
    #1;
    check("noload_stall", stall_o, 0);
    ex_valid_i = 1'b0;

    // long decode
    tick();
    ir_i = 64'h0000_0000_0056_7000;
    pc_i = 32'h0000_0100;
    #1;
    check("l_long",  long_o,  1);
    check("l_imm",   imm_o,   32'hDEAD_BEEF);
    check("l_valid", valid_o, 1);
    check("l_type",  type_o,  4'h7);

    // load-use on ra
    tick();
    ir_i = 64'h0000_0000_2011_0000;
    pc_i = 32'h0000_0104;
    ex_valid_i = 1'b1;
    ex_load_i  = 1'b1;
    ex_rd_i    = 4'h7;
    #1;
    check("rc_nonalu_stall", stall_o, 0);
    ex_rd_i = 4'h5;
    #1;
    check("lu_stall", stall_o, 1);
    check("lu_valid", valid_o, 0);
    check("lu_pc",    pc_o,    32'h100);
    tick();
    ex_valid_i = 1'b0;
    #1;
    check("lu_held_pc",  pc_o,    32'h100);
    check("lu_held_ra",  ra_o,    4'h5);
    check("lu_resume",   valid_o, 1);
    check("lu_stall_dn", stall_o, 0);

    // flush together with stall
    tick();
    check("pre_fl_pc", pc_o, 32'h104);
    stall_i = 1'b1;
    flush_i = 1'b1;
    pc_i    = 32'h0000_0200;
    #1;
    check("fl_valid", valid_o, 0);
    check("fl_stall", stall_o, 1);
    tick();
    flush_i = 1'b0;
    #1;
    check("fl_post_valid", valid_o, 0);
    check("fl_post_stall", stall_o, 1);
    check("fl_post_pc",    pc_o,    32'h200);
    tick();
    check("fl_hold_valid", valid_o, 0);
    check("fl_hold_pc",    pc_o,    32'h200);
    stall_i = 1'b0;
    #1;
    check("fl_release", stall_o, 0);

    // bubble from fetch: no valid, no hazard
    ir_i = 64'h0;
    pc_i = 32'h0000_0300;
    tick();
    ex_valid_i = 1'b1;
    ex_load_i  = 1'b1;
    ex_rd_i    = 4'h0;
    #1;
    check("bub_valid", valid_o, 0);
    check("bub_stall", stall_o, 0);
    ex_valid_i = 1'b0;

    // async reset in the middle of a hazard
    ir_i = 64'h0000_0000_0056_7000;
    pc_i = 32'h0000_0400;
    tick();
    ex_valid_i = 1'b1;
    ex_rd_i    = 4'h6;
    #1;
    check("mr_stall", stall_o, 1);
    rst_i = 1'b1;
    #1;
    check("mr_stall_rst", stall_o, 0);
    check("mr_valid_rst", valid_o, 0);
    check("mr_pc_rst",    pc_o,    0);
    ex_valid_i = 1'b0;
    ex_load_i  = 1'b0;
    ir_i       = 64'h0;
    tick();
    rst_i = 1'b0;

    // illegal type
    tick();
    ir_i = 64'h0000_0000_F000_0000;
    pc_i = 32'h0000_0500;
    tick();
    ir_i = 64'h0;
    #1;
`ifdef BEXKAT1_ILLEGAL_TRAP_EN
    check("ill_exc",   exc_o,   1);
    check("ill_valid", valid_o, 0);
    tick();
    check("ill_exc_off", exc_o, 0);
`else
    check("ill_exc",   exc_o,   0);
    check("ill_valid", valid_o, 1);
    tick();
    check("ill_exc_off", exc_o, 0);
`endif
    check("ill_next_valid", valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
